// File: rtl/nvio3_bus_pkg.sv
// Shared types and constants for the NVIO3 128-to-32 bus bridge.
package nvio3_bus_pkg;

  localparam int unsigned LANES   = 4;
  localparam int unsigned LANE_DW = 32;
  localparam int unsigned LANE_SW = 4;
  localparam int unsigned IDX_W   = 2;

  typedef logic [LANES-1:0] lane_mask_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_NEXT = 3'd2,
    ST_ACK  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // One bit per 32-bit lane: set when any byte select of that lane is active.
  function automatic lane_mask_t sel_to_mask(input logic [LANES*LANE_SW-1:0] sel);
    lane_mask_t m;
    m = '0;
    for (int k = 0; k < LANES; k++) begin
      m[k] = |sel[k*LANE_SW +: LANE_SW];
    end
    return m;
  endfunction

endpackage

// File: rtl/nvio3_lane_pick.sv
// Lowest-set-bit encoder over the 4-bit lane mask.
module nvio3_lane_pick
  import nvio3_bus_pkg::*;
(
  input  lane_mask_t       i_mask,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_vld_c
);

  // Scan from the top so the lowest set lane wins.
  always_comb begin
    o_idx_c = '0;
    o_vld_c = 1'b0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (i_mask[k]) begin
        o_idx_c = IDX_W'(k);
        o_vld_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nvio3_bridge128to32.sv
// Splits one 128-bit master beat into up to four sequential 32-bit slave
// accesses, gathers read data and returns a single ack or err.
module nvio3_bridge128to32
  import nvio3_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 255,
  parameter bit          SKIP_EMPTY = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         m_cyc_i,
  input  logic         m_stb_i,
  input  logic         m_we_i,
  input  logic [15:0]  m_sel_i,
  input  logic [31:0]  m_adr_i,
  input  logic [127:0] m_dat_i,
  output logic         m_ack_o,
  output logic         m_err_o,
  output logic [127:0] m_dat_o,
  output logic         s_cyc_o,
  output logic         s_stb_o,
  output logic         s_we_o,
  output logic [3:0]   s_sel_o,
  output logic [31:0]  s_adr_o,
  output logic [31:0]  s_dat_o,
  input  logic         s_ack_i,
  input  logic         s_err_i,
  input  logic [31:0]  s_dat_i
);

  localparam int unsigned MW    = LANES * LANE_DW;
  localparam int unsigned SW    = LANES * LANE_SW;
  localparam int unsigned AHI_W = 28;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t              r_state;
  logic                r_we;
  logic [AHI_W-1:0]    r_adr;
  logic [SW-1:0]       r_sel;
  logic [MW-1:0]       r_dat;
  lane_mask_t          r_mask;
  logic [IDX_W-1:0]    r_lane;
  logic [MW-1:0]       r_gather;
  logic [CNT_W-1:0]    r_cnt;

  state_t              w_state_nx;
  lane_mask_t          w_mask_nx;
  logic [IDX_W-1:0]    w_lane_nx;
  logic [MW-1:0]       w_gather_nx;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic                w_ld;

  lane_mask_t          w_new_mask;
  lane_mask_t          w_rem_mask;
  lane_mask_t          w_pick_in;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_vld;
  logic                w_to_hit;

  logic                w_src_we;
  logic [AHI_W-1:0]    w_src_adr;
  logic [SW-1:0]       w_src_sel;
  logic [MW-1:0]       w_src_dat;
  logic [LANE_SW-1:0]  w_drv_nib;
  logic [LANE_SW-1:0]  w_drv_sel;
  logic [LANE_DW-1:0]  w_drv_dat;
  logic [31:0]         w_drv_adr;
  logic                w_drv_wait;
  logic                w_adr_lsb_unused;

  assign w_adr_lsb_unused = ^m_adr_i[3:0];

  // Lane mask of a fresh request, and what is left after the current lane.
  assign w_new_mask = SKIP_EMPTY ? sel_to_mask(m_sel_i) : {LANES{1'b1}};
  assign w_rem_mask = r_mask & ~(lane_mask_t'(1) << r_lane);
  assign w_pick_in  = (r_state == ST_IDLE) ? w_new_mask : w_rem_mask;
  assign w_to_hit   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  nvio3_lane_pick u_pick (
    .i_mask  (w_pick_in),
    .o_idx_c (w_pick_idx),
    .o_vld_c (w_pick_vld)
  );

  // The first lane is issued from the live request; later lanes from the latch.
  assign w_src_we  = (r_state == ST_IDLE) ? m_we_i         : r_we;
  assign w_src_adr = (r_state == ST_IDLE) ? m_adr_i[31:4]  : r_adr;
  assign w_src_sel = (r_state == ST_IDLE) ? m_sel_i        : r_sel;
  assign w_src_dat = (r_state == ST_IDLE) ? m_dat_i        : r_dat;

  assign w_drv_nib  = w_src_sel[{w_lane_nx, 2'b00} +: LANE_SW];
  assign w_drv_sel  = (!SKIP_EMPTY && (w_drv_nib == '0)) ? {LANE_SW{1'b1}} : w_drv_nib;
  assign w_drv_dat  = w_src_dat[{w_lane_nx, 5'd0} +: LANE_DW];
  assign w_drv_adr  = {w_src_adr, w_lane_nx, 2'b00};
  assign w_drv_wait = (w_state_nx == ST_WAIT);

  // Next-state, lane bookkeeping, gather and timeout counter.
  always_comb begin
    w_state_nx  = r_state;
    w_mask_nx   = r_mask;
    w_lane_nx   = r_lane;
    w_gather_nx = r_gather;
    w_cnt_nx    = r_cnt;
    w_ld        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          w_ld        = 1'b1;
          w_gather_nx = '0;
          w_cnt_nx    = '0;
          w_mask_nx   = w_new_mask;
          w_lane_nx   = w_pick_idx;
          w_state_nx  = w_pick_vld ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (!m_cyc_i) begin
          w_state_nx = ST_IDLE;
        end else if (s_err_i) begin
          w_state_nx = ST_ERR;
        end else if (s_ack_i) begin
          if (!r_we) begin
            w_gather_nx[{r_lane, 5'd0} +: LANE_DW] = s_dat_i;
          end
          w_mask_nx  = w_rem_mask;
          w_lane_nx  = w_pick_idx;
          w_state_nx = w_pick_vld ? ST_NEXT : ST_ACK;
        end else if (w_to_hit) begin
          w_state_nx = ST_ERR;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      ST_NEXT: begin
        if (!m_cyc_i) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_cnt_nx   = '0;
          w_state_nx = ST_WAIT;
        end
      end
      ST_ACK:  w_state_nx = ST_IDLE;
      ST_ERR:  w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Beat latch, lane tracking and registered bus outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_sel    <= '0;
      r_dat    <= '0;
      r_mask   <= '0;
      r_lane   <= '0;
      r_gather <= '0;
      r_cnt    <= '0;
      m_ack_o  <= 1'b0;
      m_err_o  <= 1'b0;
      m_dat_o  <= '0;
      s_cyc_o  <= 1'b0;
      s_stb_o  <= 1'b0;
      s_we_o   <= 1'b0;
      s_sel_o  <= '0;
      s_adr_o  <= '0;
      s_dat_o  <= '0;
    end else begin
      if (w_ld) begin
        r_we  <= m_we_i;
        r_adr <= m_adr_i[31:4];
        r_sel <= m_sel_i;
        r_dat <= m_dat_i;
      end
      r_mask   <= w_mask_nx;
      r_lane   <= w_lane_nx;
      r_gather <= w_gather_nx;
      r_cnt    <= w_cnt_nx;
      m_ack_o  <= (w_state_nx == ST_ACK);
      m_err_o  <= (w_state_nx == ST_ERR);
      if (w_state_nx == ST_ACK) begin
        m_dat_o <= w_gather_nx;
      end
      s_cyc_o  <= w_drv_wait || (w_state_nx == ST_NEXT);
      s_stb_o  <= w_drv_wait;
      s_we_o   <= w_drv_wait && w_src_we;
      s_sel_o  <= w_drv_wait ? w_drv_sel : '0;
      s_adr_o  <= w_drv_wait ? w_drv_adr : '0;
      s_dat_o  <= w_drv_wait ? w_drv_dat : '0;
    end
  end

endmodule

// File: tb/tb_nvio3_bridge128to32.sv
// Randomized bench for the 128-to-32 bridge with a behavioural slave and beat model.
module tb_nvio3_bridge128to32;

  localparam int unsigned TO = 8;

  logic         clk;
  logic         rst_ni;
  logic         m_cyc_i, m_stb_i, m_we_i;
  logic [15:0]  m_sel_i;
  logic [31:0]  m_adr_i;
  logic [127:0] m_dat_i;
  logic         m_ack_o, m_err_o;
  logic [127:0] m_dat_o;
  logic         s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]   s_sel_o;
  logic [31:0]  s_adr_o, s_dat_o;
  logic         s_ack_i, s_err_i;
  logic [31:0]  s_dat_i;

  int n_vec = 0;
  int n_bad = 0;
  logic [127:0] last_mdat = '0;

  int           sl_ws = 0;
  int           sl_err_lane = -1;
  bit           sl_hang = 1'b0;
  logic [127:0] sl_rdat = '0;
  int           sl_wcnt = 0;
  int           sl_lane;
  logic [31:0]  acc_adr[$];
  logic [3:0]   acc_sel[$];
  logic [31:0]  acc_dat[$];
  logic         acc_we[$];

  nvio3_bridge128to32 #(.TIMEOUT(TO), .SKIP_EMPTY(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_dat_i(s_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave: answers each strobed lane after sl_ws wait cycles, logs every access.
  always @(negedge clk) begin
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_dat_i = '0;
    if (s_stb_o && !sl_hang) begin
      if (sl_wcnt >= sl_ws) begin
        sl_lane = int'(s_adr_o[3:2]);
        acc_adr.push_back(s_adr_o);
        acc_sel.push_back(s_sel_o);
        acc_dat.push_back(s_dat_o);
        acc_we.push_back(s_we_o);
        if (sl_lane == sl_err_lane) s_err_i = 1'b1;
        else begin
          s_ack_i = 1'b1;
          s_dat_i = sl_rdat[sl_lane*32 +: 32];
        end
        sl_wcnt = 0;
      end else begin
        sl_wcnt++;
      end
    end else begin
      sl_wcnt = 0;
    end
  end

  // One master beat: predict lanes, latency, outcome and data, then compare.
  task automatic run_beat(input string tag, input logic we, input logic [15:0] sel,
                          input logic [31:0] adr, input logic [127:0] dat,
                          input logic [127:0] rdat, input int ws, input int err_lane,
                          input bit hang);
    int lanes[$];
    int n_iss, n_acc, k_exp, k_got, cyc_cnt, gap_cnt, gaps_exp;
    bit exp_err, done, got_ack, got_err;
    logic [127:0] exp_dat, seen_dat;
    for (int k = 0; k < 4; k++) begin
      if (((sel >> (4 * k)) & 16'hF) != 16'h0) begin
        lanes.push_back(k);
        if (k == err_lane) break;
      end
    end
    exp_err = 1'b0;
    if (lanes.size() == 0) k_exp = 1;
    else if (hang) begin
      exp_err = 1'b1;
      k_exp = 1 + int'(TO);
    end else begin
      k_exp = lanes.size() * (ws + 2);
      exp_err = (lanes[lanes.size()-1] == err_lane);
    end
    n_iss = (hang && lanes.size() > 0) ? 1 : lanes.size();
    n_acc = hang ? 0 : lanes.size();
    gaps_exp = (n_iss > 0) ? n_iss - 1 : 0;
    if (exp_err) exp_dat = last_mdat;
    else begin
      exp_dat = '0;
      if (!we) foreach (lanes[i]) exp_dat |= rdat & (128'hFFFF_FFFF << (32 * lanes[i]));
    end

    sl_ws = ws; sl_err_lane = err_lane; sl_hang = hang; sl_rdat = rdat;
    acc_adr.delete(); acc_sel.delete(); acc_dat.delete(); acc_we.delete();

    @(negedge clk);
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
    m_sel_i = sel; m_adr_i = adr; m_dat_i = dat;
    done = 1'b0; k_got = 0; cyc_cnt = 0; gap_cnt = 0;
    got_ack = 1'b0; got_err = 1'b0; seen_dat = '0;
    for (int k = 1; k <= 300 && !done; k++) begin
      @(negedge clk);
      if (s_cyc_o) cyc_cnt++;
      if (s_cyc_o && !s_stb_o) gap_cnt++;
      if (m_ack_o || m_err_o) begin
        done = 1'b1; k_got = k;
        got_ack = m_ack_o; got_err = m_err_o; seen_dat = m_dat_o;
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
      end
    end
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    check_eq({tag, "/done"}, 128'(done), 128'(1));
    check_eq({tag, "/latency"}, 128'(k_got), 128'(k_exp));
    check_eq({tag, "/ack"}, 128'(got_ack), 128'(!exp_err));
    check_eq({tag, "/err"}, 128'(got_err), 128'(exp_err));
    check_eq({tag, "/mdat"}, seen_dat, exp_dat);
    check_eq({tag, "/cyc_cycles"}, 128'(cyc_cnt), 128'(k_exp - 1));
    check_eq({tag, "/stb_gaps"}, 128'(gap_cnt), 128'(gaps_exp));
    check_eq({tag, "/n_acc"}, 128'(acc_adr.size()), 128'(n_acc));
    for (int i = 0; i < n_acc && i < acc_adr.size(); i++) begin
      check_eq({tag, "/s_adr"}, 128'(acc_adr[i]), 128'((adr & 32'hFFFF_FFF0) + 32'(4 * lanes[i])));
      check_eq({tag, "/s_sel"}, 128'(acc_sel[i]), 128'((sel >> (4 * lanes[i])) & 16'hF));
      check_eq({tag, "/s_dat"}, 128'(acc_dat[i]), (dat >> (32 * lanes[i])) & 128'hFFFF_FFFF);
      check_eq({tag, "/s_we"}, 128'(acc_we[i]), 128'(we));
    end
    @(negedge clk);
    check_eq({tag, "/pulse"}, 128'({m_ack_o, m_err_o}), 128'(0));
    check_eq({tag, "/cyc_after"}, 128'(s_cyc_o), 128'(0));
    check_eq({tag, "/mdat_hold"}, m_dat_o, exp_dat);
    if (!exp_err) last_mdat = exp_dat;
  endtask

  initial begin
    logic [15:0] r_sel;
    int          r_err;
    bit          seen, found;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
    m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
    rst_ni = 1'b1;
    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst/m_ack", 128'(m_ack_o), 128'(0));
    check_eq("rst/m_err", 128'(m_err_o), 128'(0));
    check_eq("rst/m_dat", m_dat_o, 128'(0));
    check_eq("rst/s_bus", 128'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 128'(0));
    check_eq("rst/s_adr_dat", 128'({s_adr_o, s_dat_o}), 128'(0));
    rst_ni = 1'b1;
    @(negedge clk);

    run_beat("rd_lane3", 1'b0, 16'hF000, 32'h0000_1230, 128'h0,
             128'hDEADBEEF_00000000_00000000_00000000, 0, -1, 1'b0);
    run_beat("wr_all_ws1", 1'b1, 16'hFFFF, 32'h0000_2000,
             128'h44444444_33333333_22222222_11111111, 128'h0, 1, -1, 1'b0);
    run_beat("empty", 1'b0, 16'h0000, 32'h0000_3000, 128'h0, 128'h0, 0, -1, 1'b0);
    run_beat("err_lane0", 1'b0, 16'h0F0F, 32'h0000_4000, 128'h0,
             {4{32'hA5A5_5A5A}}, 0, 0, 1'b0);
    run_beat("timeout", 1'b0, 16'h000F, 32'h0000_5000, 128'h0, 128'h0, 0, -1, 1'b1);

    // Master abort mid-WAIT: bus drops next cycle, no completion, data kept.
    sl_ws = 3; sl_err_lane = -1; sl_hang = 1'b0;
    @(negedge clk);
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_sel_i = 16'hFFFF; m_adr_i = 32'h6000;
    repeat (2) @(negedge clk);
    check_eq("abort/stb_before", 128'(s_stb_o), 128'(1));
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge clk);
    check_eq("abort/bus_off", 128'({s_cyc_o, s_stb_o}), 128'(0));
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (m_ack_o || m_err_o || s_cyc_o) seen = 1'b1;
    end
    check_eq("abort/quiet", 128'(seen), 128'(0));
    check_eq("abort/mdat", m_dat_o, last_mdat);

    // Async reset while lane 1 is waiting.
    sl_ws = 3;
    @(negedge clk);
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_sel_i = 16'hFFFF; m_adr_i = 32'h7000;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (s_stb_o && s_adr_o[3:2] == 2'd1) found = 1'b1;
    end
    check_eq("arst/reach_lane1", 128'(found), 128'(1));
    @(posedge clk);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("arst/bus_off", 128'({s_cyc_o, s_stb_o}), 128'(0));
    check_eq("arst/m_dat", m_dat_o, 128'(0));
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    last_mdat = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    run_beat("after_rst", 1'b0, 16'h000F, 32'h0000_8000, 128'h0,
             {$urandom, $urandom, $urandom, $urandom}, 0, -1, 1'b0);

    // Randomized beats.
    for (int t = 0; t < 40; t++) begin
      r_sel = '0;
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 9) >= 3) r_sel[k*4 +: 4] = 4'($urandom_range(1, 15));
      end
      r_err = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_beat("rand", 1'($urandom_range(0, 1)), r_sel, $urandom,
               {$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom},
               int'($urandom_range(0, 2)), r_err, ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/nvio3_bridge128to32.md
Name: nvio3_bridge128to32

Overview:
Downstream bus bridge on the NVIO3 MPU's 128-bit external bus. It turns each 128-bit master beat (cyc/stb/we/sel[15:0]) into one to four sequential 32-bit slave accesses, one per active 4-byte lane. Read data is gathered back into 128 bits, and a single ack (or err) is returned to the MPU. Off-chip 32-bit peripherals hang on the slave side.

Parameters:
TIMEOUT, 255, slave-ack wait limit in cycles per lane; 0 disables the timeout.
SKIP_EMPTY, 1, 1 = lanes with a zero sel nibble generate no slave access; 0 = all four lanes are accessed.

Ports:
clk_i  in  1  bus clock
rst_ni  in  1  asynchronous reset, active low
m_cyc_i  in  1  master cycle
m_stb_i  in  1  master strobe
m_we_i  in  1  master write
m_sel_i  in  16  master byte selects
m_adr_i  in  32  master address; bits [3:0] are ignored
m_dat_i  in  128  master write data
m_ack_o  out  1  beat complete (one-cycle pulse)
m_err_o  out  1  beat failed (one-cycle pulse)
m_dat_o  out  128  gathered read data
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_we_o  out  1  slave write
s_sel_o  out  4  slave byte selects
s_adr_o  out  32  slave address
s_dat_o  out  32  slave write data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave error
s_dat_i  in  32  slave read data

Behaviour:
- Reset (async, rst_ni=0):
  - All outputs are 0; state is IDLE.
  - s_cyc_o/s_stb_o drop immediately, even mid-transfer.
- All outputs are registered.
- States: IDLE, WAIT, NEXT, ACK, ERR.
- IDLE:
  - On m_cyc_i & m_stb_i: latch we, adr[31:4], dat, and the lane mask (bit k = |m_sel_i[4k+3:4k]; all ones if SKIP_EMPTY=0).
  - Clear the gather register.
  - Mask == 0 → ACK, with no slave access.
  - Otherwise select the lowest set lane k and go to WAIT, asserting s_cyc_o=s_stb_o=1.
- Slave drive while in WAIT:
  - s_adr_o = {adr[31:4], k[1:0], 2'b00}
  - s_sel_o = sel nibble k; 4'hF for an empty lane when SKIP_EMPTY=0
  - s_dat_o = dat[32k+31:32k]
  - s_we_o = latched we
- WAIT, on s_ack_i:
  - Reads: gather[32k+31:32k] ← s_dat_i.
  - Clear mask bit k and drop s_stb_o.
  - Remaining mask ≠ 0 → NEXT (s_cyc_o held 1, s_stb_o 0 for exactly one cycle), then WAIT on the next lowest lane.
  - Remaining mask == 0 → ACK.
- WAIT, on s_err_i (priority over s_ack_i in the same cycle): go to ERR. The remaining lanes are not issued.
- WAIT, timeout: a per-lane counter resets on lane entry. On reaching TIMEOUT with no ack or err → ERR.
- ACK:
  - m_ack_o=1 for one cycle; s_cyc_o=0.
  - m_dat_o = gather. Lanes that were not read are 0.
  - m_dat_o holds its value until the next beat completes.
  - Then IDLE.
- ERR: m_err_o=1 for one cycle; s_cyc_o=0; m_dat_o is not updated. Then IDLE.
- Master abort: m_cyc_i=0 while in WAIT or NEXT → drop s_cyc/s_stb next cycle and go to IDLE. No m_ack/m_err is issued and the gather register is discarded.
- Latency: request at T0 with a slave acking in the same cycle → m_ack_o at T(2n), n = number of lanes issued; n=0 gives T1.
- Back-to-back beats: IDLE samples a new request in the cycle after ACK/ERR. The master must deassert stb or present the new beat on its ack cycle, per classic bus rules.
- Counter width is $clog2(TIMEOUT+1) and saturates.

Decomposition:
- Package nvio3_bus_pkg holds:
  - the state enum (IDLE, WAIT, NEXT, ACK, ERR);
  - the LANES=4 constant;
  - the lane-mask typedef logic[3:0].
- Sub-module nvio3_lane_pick: combinational lowest-set-bit encoder, 4-bit mask in → 2-bit index plus valid. Used in IDLE and in the WAIT→NEXT transition.

Test Plan:
- Read, sel=16'hF000, adr=32'h0000_1230, slave acks the first stb cycle with 32'hDEADBEEF → one slave access at adr 32'h0000_123C, sel 4'hF; m_dat_o=128'hDEADBEEF_00000000_00000000_00000000; m_ack_o at T2.
- Write, sel=16'hFFFF, dat=128'h44444444_33333333_22222222_11111111, slave with 1 wait state → lanes 0..3 in order at adr ...0, ...4, ...8, ...C with data 11111111..44444444; s_stb_o low for one cycle between lanes with s_cyc_o held high; single m_ack_o at T12.
- sel=16'h0000 → no s_cyc_o; m_ack_o at T1; m_dat_o=0.
- sel=16'h0F0F, slave raises s_err_i on lane 0 → ERR; lane 2 is never issued; m_err_o pulses once; m_ack_o stays 0.
- TIMEOUT=8, slave never acks → m_err_o asserted 8 cycles after s_stb_o rises; s_cyc_o low the following cycle.
- rst_ni pulled low mid-WAIT on lane 1 → s_cyc_o/s_stb_o go 0 with no clock edge; after release a fresh sel=16'h000F read completes normally.
